// File: rtl/walls_map_arbiter.sv
// Wall-map RAM arbiter: full-map clear, renderer reads, and buffered SoC writes.
// Optional WALLS_WRITE_COUNT_EN adds a saturating write_count output.
module walls_map_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CLEAR_VALUE  = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] walls_addr,
   input  logic [DATA_W-1:0] walls_data,
   input  logic              walls_we,
   input  logic              screen_reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
`ifdef WALLS_WRITE_COUNT_EN
   output logic [15:0]       write_count,
`endif
   output logic              overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = ADDR_W + DATA_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [EW-1:0]     fifo_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic              we_q, sr_q, overflow_q, rd_valid_q;
   logic              push, clr_req, pop, push_ok, empty, full;
   logic [EW-1:0]     head;

   assign push    = walls_we & ~we_q;
   assign clr_req = screen_reset & ~sr_q;
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == DEPTH_C);
   assign head    = fifo_q[rd_ptr_q];
   // A flush or a same-cycle pop frees room before the push lands.
   assign push_ok = push & (clr_req | ~full | pop);

   assign rd_valid = rd_valid_q;
   assign rd_data  = ram_rdata;
   assign busy     = (state_q == S_CLEAR);
   assign overflow = overflow_q;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      starve_d  = starve_q;
      pop       = 1'b0;
      rd_grant  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (state_q)
         S_CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = DATA_W'(CLEAR_VALUE);
            clr_cnt_d = clr_cnt_q + 1'b1;
            starve_d  = '0;
            if (clr_cnt_q == '1) state_d = S_RUN;
         end
         S_RUN: begin
            if (rd_req && (empty || starve_q < SLIM)) begin
               rd_grant = 1'b1;
               ram_addr = rd_addr;
            end else if (!empty) begin
               pop       = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = head[EW-1:DATA_W];
               ram_wdata = head[DATA_W-1:0];
            end
            if (empty || pop) starve_d = '0;
            else if (starve_q != SLIM) starve_d = starve_q + 1'b1;
         end
      endcase
      if (clr_req) begin
         state_d   = S_CLEAR;
         clr_cnt_d = '0;
      end
      if (Reset) begin
         pop       = 1'b0;
         rd_grant  = 1'b0;
         ram_we    = 1'b0;
         ram_addr  = '0;
         ram_wdata = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_CLEAR;
         clr_cnt_q  <= '0;
         starve_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         we_q       <= 1'b1;
         sr_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         starve_q   <= starve_d;
         rd_valid_q <= rd_grant;
         we_q       <= walls_we;
         sr_q       <= screen_reset;
         if (push & ~push_ok) overflow_q <= 1'b1;
         if (clr_req) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= PW'(push);
            cnt_q    <= CW'(push);
         end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && push_ok)
         fifo_q[clr_req ? '0 : wr_ptr_q] <= {walls_addr, walls_data};
   end

`ifdef WALLS_WRITE_COUNT_EN
   logic [15:0] wcnt_q;

   always_ff @(posedge Clk) begin
      if (Reset || clr_req) wcnt_q <= '0;
      else if (pop && wcnt_q != 16'hFFFF) wcnt_q <= wcnt_q + 1'b1;
   end

   assign write_count = wcnt_q;
`endif

endmodule

// File: tb/tb_walls_map_arbiter.sv
// Self-checking bench for walls_map_arbiter with a behavioural RAM and
// a queue-based reference model of the write path.
module tb_walls_map_arbiter;

   localparam int STARVE = 8;
   localparam int DEPTH  = 4;

   logic       Clk, Reset;
   logic [7:0] walls_addr, walls_data;
   logic       walls_we, screen_reset, rd_req;
   logic [7:0] rd_addr;
   logic       rd_grant, rd_valid;
   logic [7:0] rd_data, ram_addr, ram_wdata, ram_rdata;
   logic       ram_we, busy, overflow;
`ifdef WALLS_WRITE_COUNT_EN
   logic [15:0] write_count;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] ram_m [256];

   walls_map_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .walls_addr(walls_addr), .walls_data(walls_data),
      .walls_we(walls_we), .screen_reset(screen_reset),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .busy(busy),
`ifdef WALLS_WRITE_COUNT_EN
      .write_count(write_count),
`endif
      .overflow(overflow)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always_ff @(posedge Clk) begin
      if (ram_we) ram_m[ram_addr] <= ram_wdata;
      ram_rdata <= ram_m[ram_addr];
   end

   task automatic do_reset();
      bit ok = 0;
      @(negedge Clk);
      Reset = 1; walls_we = 0; screen_reset = 0; rd_req = 0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk); #1;
         if (busy === 1'b0) begin ok = 1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL reset_clear_done busy=%b exp=0", busy); end
   endtask

   task automatic test_reset();
      Reset = 1; walls_we = 1; screen_reset = 1;
      rd_req = 1; rd_addr = 8'h55;
      walls_addr = 8'hFF; walls_data = 8'hFF;
      repeat (3) @(negedge Clk);
      #1;
      total++; if (rd_grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%b exp=0", rd_grant); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", ram_we); end
      total++; if (ram_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", ram_addr); end
      total++; if (ram_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h exp=00", ram_wdata); end
      @(negedge Clk);
      Reset = 0; rd_req = 0;
      for (int i = 0; i < 256; i++) begin
         if (i > 0) @(negedge Clk);
         #1;
         total++;
         if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'(i) || ram_wdata !== 8'h00) begin
            bad++;
            $display("FAIL clear_cycle i=%0d busy=%b we=%b addr=%h data=%h exp addr=%h",
                     i, busy, ram_we, ram_addr, ram_wdata, 8'(i));
         end
      end
      @(negedge Clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_end busy=%b exp=0", busy); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL held_strobe_we got=%b exp=0", ram_we); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b exp=0", rd_valid); end
      @(negedge Clk);
      walls_we = 0; screen_reset = 0;
   endtask

   task automatic test_write_read();
      bit found = 0;
      @(negedge Clk);
      walls_addr = 8'h12; walls_data = 8'hA5; walls_we = 1;
      for (int k = 0; k < 3 && !found; k++) begin
         @(negedge Clk);
         walls_we = 0;
         #1;
         if (ram_we === 1'b1 && ram_addr === 8'h12) begin
            found = 1;
            total++;
            if (ram_wdata !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h exp=a5", ram_wdata); end
         end
      end
      total++; if (!found) begin bad++; $display("FAIL wr_seen got=0 exp=1"); end
      @(negedge Clk);
      rd_req = 1; rd_addr = 8'h12;
      #1;
      total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL rd_grant got=%b exp=1", rd_grant); end
      @(negedge Clk);
      rd_req = 0;
      #1;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", rd_valid); end
      total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h exp=a5", rd_data); end
   endtask

   task automatic test_starve();
      int grants = 0;
      bit done = 0;
      @(negedge Clk);
      rd_req = 1; rd_addr = 8'h33;
      walls_addr = 8'h40; walls_data = 8'h77; walls_we = 1;
      #1;
      total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL stv_first got=%b exp=1", rd_grant); end
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge Clk);
         walls_we = 0;
         #1;
         if (ram_we === 1'b1) begin
            done = 1;
            total++; if (grants != STARVE) begin bad++; $display("FAIL stv_grants got=%0d exp=%0d", grants, STARVE); end
            total++; if (rd_grant !== 1'b0) begin bad++; $display("FAIL stv_forced_grant got=%b exp=0", rd_grant); end
            total++;
            if (ram_addr !== 8'h40 || ram_wdata !== 8'h77) begin
               bad++; $display("FAIL stv_write got=%h/%h exp=40/77", ram_addr, ram_wdata);
            end
         end else if (rd_grant === 1'b1) grants++;
      end
      total++; if (!done) begin bad++; $display("FAIL stv_timeout got=0 exp=1"); end
      @(negedge Clk); #1;
      total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL stv_resume got=%b exp=1", rd_grant); end
   endtask

   task automatic test_overflow();
      bit ok = 0;
      int n = 0;
      @(negedge Clk);
      rd_req = 0; screen_reset = 1;
      @(negedge Clk);
      screen_reset = 0;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b exp=1", busy); end
      for (int e = 0; e < 5; e++) begin
         @(negedge Clk);
         walls_addr = 8'(128 + e); walls_data = 8'(16 + e); walls_we = 1;
         @(negedge Clk);
         walls_we = 0;
      end
      #1;
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk); #1;
         if (busy === 1'b0) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL ovf_clear_end got=busy exp=idle"); end
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(negedge Clk); #1; end
         if (ram_we === 1'b1) begin
            total++;
            if (n >= 4 || ram_addr !== 8'(128 + n) || ram_wdata !== 8'(16 + n)) begin
               bad++; $display("FAIL ovf_order n=%0d got=%h/%h", n, ram_addr, ram_wdata);
            end
            n++;
         end
      end
      total++; if (n != 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", n); end
   endtask

   task automatic test_restart();
      bit ok = 0;
      int cnt = 1;
      int n = 0;
      @(negedge Clk);
      screen_reset = 1;
      @(negedge Clk);
      screen_reset = 0;
      for (int e = 0; e < 2; e++) begin
         @(negedge Clk);
         walls_addr = 8'(33 + e); walls_data = 8'(49 + e); walls_we = 1;
         @(negedge Clk);
         walls_we = 0;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk); #1;
         if (busy === 1'b1 && ram_addr === 8'd100) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL rst100_reach got=0 exp=1"); end
      screen_reset = 1; walls_we = 1;
      walls_addr = 8'h77; walls_data = 8'h5C;
      @(negedge Clk);
      screen_reset = 0; walls_we = 0;
      #1;
      total++;
      if (busy !== 1'b1 || ram_addr !== 8'h00) begin
         bad++; $display("FAIL restart_addr got=%h busy=%b exp=00", ram_addr, busy);
      end
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk); #1;
         if (busy === 1'b1) cnt++;
         else begin ok = 1; break; end
      end
      total++; if (!ok || cnt != 256) begin bad++; $display("FAIL restart_len got=%0d exp=256", cnt); end
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(negedge Clk); #1; end
         if (ram_we === 1'b1) begin
            total++;
            if (ram_addr !== 8'h77 || ram_wdata !== 8'h5C) begin
               bad++; $display("FAIL restart_write got=%h/%h exp=77/5c", ram_addr, ram_wdata);
            end
            n++;
         end
      end
      total++; if (n != 1) begin bad++; $display("FAIL restart_count got=%0d exp=1", n); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_random();
      logic [15:0] q[$];
      logic [7:0]  exp_map [256];
      logic        exp_ovf = 0;
      logic        prev_grant = 0;
      logic        prev_we = 0;
      logic        drop_rd = 0;
      logic        push_m;
      logic [7:0]  prev_raddr = 0;
      int          consec = 0;
      int          qsz;
      do_reset();
      foreach (exp_map[i]) exp_map[i] = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         if (drop_rd) begin rd_req = 0; drop_rd = 0; end
         if (!rd_req && ((c < 1500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0))) begin
            rd_req = 1; rd_addr = 8'($urandom_range(0, 15));
         end
         if (walls_we) walls_we = 0;
         else if ($urandom_range(0, 2) == 0) begin
            walls_we = 1;
            walls_addr = 8'($urandom_range(0, 15));
            walls_data = 8'($urandom);
         end
         push_m = walls_we && !prev_we;
         prev_we = walls_we;
         #1;
         total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, exp_ovf); end
         total++; if (rd_valid !== prev_grant) begin bad++; $display("FAIL rnd_rdv c=%0d got=%b exp=%b", c, rd_valid, prev_grant); end
         if (prev_grant) begin
            total++;
            if (rd_data !== exp_map[prev_raddr]) begin
               bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rd_data, exp_map[prev_raddr]);
            end
         end
         qsz = q.size();
         if (ram_we === 1'b1) begin
            total++;
            if (qsz == 0) begin bad++; $display("FAIL rnd_spurious c=%0d got=%h/%h exp=none", c, ram_addr, ram_wdata); end
            else if ({ram_addr, ram_wdata} !== q[0]) begin
               bad++; $display("FAIL rnd_write c=%0d got=%h exp=%h", c, {ram_addr, ram_wdata}, q[0]);
            end
            if (qsz > 0) begin
               exp_map[q[0][15:8]] = q[0][7:0];
               void'(q.pop_front());
            end
            consec = 0;
            total++; if (rd_grant !== 1'b0) begin bad++; $display("FAIL rnd_both c=%0d got=%b exp=0", c, rd_grant); end
         end else if (qsz > 0) begin
            consec++;
            total++;
            if (!rd_req || consec > STARVE) begin
               bad++; $display("FAIL rnd_starve c=%0d got=%0d exp<=%0d rd_req=%b", c, consec, STARVE, rd_req);
            end
         end
         if (rd_req && qsz == 0) begin
            total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL rnd_idle_grant c=%0d got=%b exp=1", c, rd_grant); end
         end
         if (rd_grant === 1'b1) begin
            total++;
            if (!rd_req || ram_addr !== rd_addr) begin
               bad++; $display("FAIL rnd_grant_addr c=%0d got=%h exp=%h", c, ram_addr, rd_addr);
            end
            drop_rd = 1;
            prev_raddr = rd_addr;
         end
         prev_grant = (rd_grant === 1'b1);
         if (push_m) begin
            if (q.size() < DEPTH) q.push_back({walls_addr, walls_data});
            else exp_ovf = 1;
         end
      end
      @(negedge Clk);
      rd_req = 0; walls_we = 0;
   endtask

`ifdef WALLS_WRITE_COUNT_EN
   task automatic test_write_count();
      bit ok = 0;
      @(negedge Clk);
      rd_req = 0; walls_we = 0; screen_reset = 1;
      @(negedge Clk);
      screen_reset = 0;
      #1;
      total++; if (write_count !== 16'd0) begin bad++; $display("FAIL wc_clear0 got=%0d exp=0", write_count); end
      for (int k = 0; k < 300; k++) begin
         @(negedge Clk); #1;
         if (busy === 1'b0) begin ok = 1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL wc_clear_end got=busy exp=idle"); end
      for (int w = 0; w < 3; w++) begin
         @(negedge Clk);
         walls_addr = 8'(144 + w); walls_data = 8'(w); walls_we = 1;
         @(negedge Clk);
         walls_we = 0;
      end
      repeat (3) @(negedge Clk);
      #1;
      total++; if (write_count !== 16'd3) begin bad++; $display("FAIL wc_three got=%0d exp=3", write_count); end
      @(negedge Clk);
      screen_reset = 1;
      @(negedge Clk);
      screen_reset = 0;
      #1;
      total++; if (write_count !== 16'd0) begin bad++; $display("FAIL wc_cleared got=%0d exp=0", write_count); end
   endtask
`endif

   initial begin
      Reset = 1; walls_we = 0; screen_reset = 0;
      rd_req = 0; rd_addr = 0; walls_addr = 0; walls_data = 0;
      test_reset();
      test_write_read();
      test_starve();
      test_overflow();
      test_restart();
      test_random();
`ifdef WALLS_WRITE_COUNT_EN
      test_write_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/walls_map_arbiter.md
Name: walls_map_arbiter

Overview:
- Owns the single-port 256x8 wall-map RAM.
- Sequences three users of that RAM:
  - wall writes from the SoC, arriving on the walls_addr/walls_data/walls_we PIO exports;
  - per-pixel wall reads from the renderer;
  - a full-map clear on reset or on a screen_reset request.
- Renderer reads have priority. SoC writes are buffered in a small FIFO and guaranteed service by a starvation limit.

Parameters:
- ADDR_W, 8, wall RAM address width (RAM depth 2^ADDR_W)
- DATA_W, 8, wall RAM data width
- FIFO_DEPTH, 4, SoC write FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles a pending write may lose to reads before it is forced
- CLEAR_VALUE, 0, word written to every address during clear

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- walls_addr  in  ADDR_W  SoC wall address (PIO)
- walls_data  in  DATA_W  SoC wall data (PIO)
- walls_we  in  1  SoC write strobe level; rising edge commits one write
- screen_reset  in  1  rising edge requests full-map clear
- rd_req  in  1  renderer read request
- rd_addr  in  ADDR_W  renderer read address
- rd_grant  out  1  read accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after grant)
- rd_data  out  DATA_W  read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM registered read data (1-cycle latency)
- busy  out  1  clear in progress
- overflow  out  1  sticky: a SoC write was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high), applied with Reset high:
  - state := CLEAR; clr_cnt := 0; FIFO emptied; starve_cnt := 0; overflow := 0; rd_valid := 0.
  - we_q := 1 and sr_q := 1, so a strobe held high through reset is not taken as an edge.
  - Combinational outputs are forced to 0 while Reset is high: rd_grant, ram_we, ram_addr, ram_wdata.
  - busy = 1 from the first cycle after reset.
- Write capture:
  - push = walls_we & ~we_q. Push {walls_addr, walls_data}, sampled in the edge cycle.
  - Push while FIFO full: entry dropped, overflow := 1. overflow is cleared only by Reset.
  - Captures occur in every state.
- CLEAR state:
  - Each cycle: ram_we=1, ram_addr=clr_cnt, ram_wdata=CLEAR_VALUE; clr_cnt increments.
  - After address 2^ADDR_W-1 is written, go to RUN next cycle. Total 2^ADDR_W cycles.
  - rd_grant=0 throughout; FIFO is not popped.
- Clear request (screen_reset & ~sr_q):
  - From RUN: enter CLEAR next cycle with clr_cnt=0 and the FIFO flushed.
  - From CLEAR: clr_cnt restarts at 0 and the FIFO is flushed.
  - Flush and push in the same cycle: the flush happens first, so the new entry is kept (FIFO count=1).
  - Writes pushed during CLEAR are retained and applied after the clear.
- RUN state, evaluated each cycle:
  - Read wins if rd_req and (FIFO empty or starve_cnt < STARVE_LIMIT). Then rd_grant=1, ram_addr=rd_addr, ram_we=0.
  - Otherwise, if the FIFO is non-empty: pop the head; ram_we=1, ram_addr/ram_wdata = head.
  - starve_cnt:
    - +1 on a cycle where the FIFO is non-empty and no write is performed;
    - := 0 on a performed write or when the FIFO is empty;
    - saturates at STARVE_LIMIT.
  - A forced write sets rd_grant=0 that cycle. The renderer holds rd_req/rd_addr until granted.
- Read data timing:
  - rd_valid registered = rd_grant delayed one cycle.
  - rd_data = ram_rdata, passed through unregistered.
- FIFO ordering:
  - Writes retire in capture order.
  - Two writes to the same address: the last one wins.
  - Push and pop in the same cycle when full: the pop frees the slot first, so no overflow.

Optional Feature:
- Macro: WALLS_WRITE_COUNT_EN.
- When defined:
  - adds output write_count [15:0], reset to 0;
  - increments on each RAM write performed from the FIFO (clear writes are not counted);
  - saturates at 16'hFFFF;
  - cleared on each clear request.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset released -> busy=1 for exactly 256 cycles; ram_we=1 with ram_addr 0..255 and ram_wdata=0; then busy=0, state RUN.
- In RUN, idle reads: walls_addr=8'h12, walls_data=8'hA5, walls_we pulse -> ram_we=1 at addr 12, data A5 within 3 cycles. Then rd_req with rd_addr=8'h12 -> rd_grant same cycle, rd_valid next cycle with rd_data=A5.
- rd_req held high continuously while one write is pending -> 8 read grants, then one forced write with rd_grant=0, then reads resume; starve_cnt back to 0.
- Five walls_we edges during CLEAR with FIFO_DEPTH=4 -> overflow=1; the first 4 writes are applied in order after busy falls; the 5th is never written.
- screen_reset edge at clr_cnt=100 with 2 entries queued before it -> clear restarts at addr 0 (256 more cycles) and the FIFO is empty. A walls_we edge in that same cycle -> exactly 1 write applied after the clear.
- With WALLS_WRITE_COUNT_EN: 3 SoC writes -> write_count=3; then a screen_reset edge -> write_count=0.
